unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch port (imem side) and the
//  MEM-stage load/store port (dmem side) of the 5-stage pipeline. It allows one outstanding

---
 rtl/unified_mem_arbiter.sv | 113 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between fetch and load/store ports.
// Optional macro ARB_BACK2BACK_EN: re-arbitrate in the response cycle for zero-bubble issue.
module unified_mem_arbiter #(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DATAW-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [1:0]       d_size,
    input  logic [ADDRW-1:0] d_addr,
    input  logic [DATAW-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DATAW-1:0] d_rdata,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [1:0]       mem_size,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [DATAW-1:0] mem_rdata,
    output logic             busy
);

    localparam int CNTW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_D
    } state_t;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   starve_cnt;
    logic              owner_we;
    logic              resp;
    logic              decide;
    logic              fetch_forced;

    always_comb begin
        resp         = !reset && (state != IDLE) && mem_rvalid;
        decide       = !reset && (state == IDLE);
`ifdef ARB_BACK2BACK_EN
        if (resp) begin
            decide = 1'b1;
        end
`endif
        fetch_forced = if_req && (starve_cnt == CNTW'(STARVE_MAX));
        if_gnt       = decide && if_req && (fetch_forced || !d_req);
        d_gnt        = decide && d_req && !fetch_forced;

        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_valid = 1'b1;
            mem_size  = 2'b10;
            mem_addr  = if_addr;
        end else if (d_gnt) begin
            mem_valid = 1'b1;
            mem_we    = d_we;
            mem_size  = d_size;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end

        if_rvalid = resp && (state == WAIT_IF);
        d_rvalid  = resp && (state == WAIT_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;
        busy      = (state != IDLE);

        // A grant in the response cycle overrides the return to IDLE.
        state_nxt = state;
        if (resp) begin
            state_nxt = IDLE;
        end
        if (if_gnt) begin
            state_nxt = WAIT_IF;
        end else if (d_gnt) begin
            state_nxt = WAIT_D;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner_we   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (d_gnt) begin
                owner_we <= d_we;
            end
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && (starve_cnt != CNTW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed corner cases, then random traffic
// against a behavioural memory and arbitration reference model.
module tb_unified_mem_arbiter;

    localparam int DATAW      = 32;
    localparam int ADDRW      = 32;
    localparam int STARVE_MAX = 4;
    localparam int TMO        = 60;
    localparam int NTXN       = 150;

    logic             clock = 1'b0;
    logic             reset;
    logic             if_req, if_gnt, if_rvalid;
    logic [ADDRW-1:0] if_addr;
    logic [DATAW-1:0] if_rdata;
    logic             d_req, d_we, d_gnt, d_rvalid;
    logic [1:0]       d_size;
    logic [ADDRW-1:0] d_addr;
    logic [DATAW-1:0] d_wdata, d_rdata;
    logic             mem_valid, mem_we, mem_rvalid, busy;
    logic [1:0]       mem_size;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    unified_mem_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

`ifdef ARB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];

    bit mon_en    = 1'b0;
    bit mem_stop  = 1'b0;
    int fixed_lat = 1;
    int streak_m;
    bit outst_m;
    bit owner_if_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    // Memory device: captures an issue at the negedge, answers after 1..3 cycles.
    task automatic mem_task();
        bit          pend = 1'b0;
        int          cnt  = 0;
        logic [31:0] rd   = '0;
        while (!mem_stop) begin
            @(negedge clock);
            if (mem_valid) begin
                if (mem_we) begin
                    dev_mem[mem_addr] = mem_wdata;
                    rd = $urandom;
                end else begin
                    rd = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_word(mem_addr);
                end
                pend = 1'b1;
                cnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            end
            @(posedge clock);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd;
                    pend       = 1'b0;
                end
            end
        end
    endtask

    task automatic fetch_task(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            repeat ($urandom_range(0, 2)) step();
            if_req  = 1'b1;
            if_addr = 32'h0100_0000 + 32'($urandom_range(0, 63)) * 4;
            k = 0;
            do begin samp(); k++; end while (!if_gnt && k < TMO);
            if (!if_gnt) chk("if_gnt_timeout", 64'(k), 64'(TMO + 1));
            exp_if_q.push_back(init_word(if_addr));
            step();
            if_req = 1'b0;
            k = 0;
            while (!if_rvalid && k < TMO) begin samp(); k++; end
            if (!if_rvalid) chk("if_rvalid_timeout", 64'(k), 64'(TMO + 1));
        end
    endtask

    task automatic data_task(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            repeat ($urandom_range(0, 1)) step();
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_size  = 2'($urandom_range(0, 2));
            d_addr  = 32'h0100_1000 + 32'($urandom_range(0, 15)) * 4;
            d_wdata = $urandom;
            k = 0;
            do begin samp(); k++; end while (!d_gnt && k < TMO);
            if (!d_gnt) chk("d_gnt_timeout", 64'(k), 64'(TMO + 1));
            if (d_we) begin
                exp_d_q.push_back('0);
                model_mem[d_addr] = d_wdata;
            end else begin
                exp_d_q.push_back(model_mem.exists(d_addr) ? model_mem[d_addr] : init_word(d_addr));
            end
            step();
            d_req = 1'b0;
            k = 0;
            while (!d_rvalid && k < TMO) begin samp(); k++; end
            if (!d_rvalid) chk("d_rvalid_timeout", 64'(k), 64'(TMO + 1));
        end
    endtask

    // Monitor: checks responses from the scoreboard and grants against the arbitration rules.
    always @(negedge clock) begin
        if (mon_en) begin
            bit allowed;
            chk("both_gnt", 64'(if_gnt && d_gnt), 64'(0));
            chk("busy", 64'(busy), 64'(outst_m));
            chk("if_rvalid", 64'(if_rvalid), 64'(outst_m && mem_rvalid && owner_if_m));
            chk("d_rvalid", 64'(d_rvalid), 64'(outst_m && mem_rvalid && !owner_if_m));
            if (if_rvalid) begin
                if (exp_if_q.size() == 0) chk("if_unexpected", 64'(1), 64'(0));
                else chk("if_rdata", 64'(if_rdata), 64'(exp_if_q.pop_front()));
            end
            if (d_rvalid) begin
                if (exp_d_q.size() == 0) chk("d_unexpected", 64'(1), 64'(0));
                else chk("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
            end
            allowed = !outst_m || (B2B && mem_rvalid);
            chk("gnt_taken", 64'(if_gnt || d_gnt), 64'(allowed && (if_req || d_req)));
            if (if_req && d_req && (if_gnt || d_gnt))
                chk("winner_if", 64'(if_gnt), 64'(streak_m == STARVE_MAX));
            if (if_gnt) begin
                chk("if_mem_valid", 64'(mem_valid), 64'(1));
                chk("if_mem_addr", 64'(mem_addr), 64'(if_addr));
                chk("if_mem_we", 64'(mem_we), 64'(0));
                chk("if_mem_wdata", 64'(mem_wdata), 64'(0));
            end
            if (d_gnt) begin
                chk("d_mem_valid", 64'(mem_valid), 64'(1));
                chk("d_mem_addr", 64'(mem_addr), 64'(d_addr));
                chk("d_mem_we", 64'(mem_we), 64'(d_we));
                chk("d_mem_size", 64'(mem_size), 64'(d_size));
                chk("d_mem_wdata", 64'(mem_wdata), 64'(d_wdata));
            end
            if (!if_gnt && !d_gnt) chk("idle_mem_valid", 64'(mem_valid), 64'(0));
            if (outst_m && mem_rvalid) outst_m = 1'b0;
            if (if_gnt || d_gnt) begin
                outst_m    = 1'b1;
                owner_if_m = if_gnt;
            end
            if (!if_req || if_gnt) streak_m = 0;
            else if (d_gnt && streak_m < STARVE_MAX) streak_m++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seq[6];
        bit exp_seq[6];
        int got;
        int k;

        reset = 1'b1; if_req = 1'b1; if_addr = 32'h0100_0000;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        repeat (3) step();
        samp();
        chk("rst_if_gnt", 64'(if_gnt), 64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        step();
        reset = 1'b0; if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Fetch only, memory answers two cycles after issue
        step();
        if_req = 1'b1; if_addr = 32'h0100_0000;
        samp();
        chk("t1_if_gnt", 64'(if_gnt), 64'(1));
        chk("t1_mem_addr", 64'(mem_addr), 64'h0100_0000);
        chk("t1_mem_we", 64'(mem_we), 64'(0));
        step(); if_req = 1'b0;
        samp();
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_no_early_rvalid", 64'(if_rvalid), 64'(0));
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        samp();
        chk("t1_if_rvalid", 64'(if_rvalid), 64'(1));
        chk("t1_if_rdata", 64'(if_rdata), 64'h13);
        chk("t1_d_rvalid", 64'(d_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0;
        samp();
        chk("t1_idle", 64'(busy), 64'(0));

        // Stale response while idle must be ignored
        step(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        samp();
        chk("stale_if_rvalid", 64'(if_rvalid), 64'(0));
        chk("stale_d_rvalid", 64'(d_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0;

        // Simultaneous requests: data first, fetch after the data response
        if_req = 1'b1; if_addr = 32'h0100_0004;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0100_0100;
        samp();
        chk("t2_d_gnt", 64'(d_gnt), 64'(1));
        chk("t2_if_gnt", 64'(if_gnt), 64'(0));
        chk("t2_mem_addr", 64'(mem_addr), 64'h0100_0100);
        step(); d_req = 1'b0;
        samp();
        chk("t2_if_wait", 64'(if_gnt), 64'(0));
        step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        samp();
        chk("t2_d_rvalid", 64'(d_rvalid), 64'(1));
        chk("t2_d_rdata", 64'(d_rdata), 64'hCAFE_F00D);
        chk("t6_if_gnt_rsp_cycle", 64'(if_gnt), 64'(B2B));
        step(); mem_rvalid = 1'b0;
        samp();
        chk("t6_if_gnt_after", 64'(if_gnt), 64'(!B2B));
        step(); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
        samp();
        chk("t2_if_rvalid", 64'(if_rvalid), 64'(1));
        chk("t2_if_rdata", 64'(if_rdata), 64'h93);
        step(); mem_rvalid = 1'b0;

        // Store
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0100_0200; d_wdata = 32'hDEAD_BEEF;
        samp();
        chk("t4_d_gnt", 64'(d_gnt), 64'(1));
        chk("t4_mem_we", 64'(mem_we), 64'(1));
        chk("t4_mem_size", 64'(mem_size), 64'(2));
        chk("t4_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        step(); d_req = 1'b0; d_we = 1'b0;
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        samp();
        chk("t4_d_rvalid", 64'(d_rvalid), 64'(1));
        chk("t4_d_rdata", 64'(d_rdata), 64'(0));
        chk("t4_if_rvalid", 64'(if_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0;

        // Reset while waiting for a load response
        d_req = 1'b1; d_addr = 32'h0100_0300;
        samp();
        chk("t5_d_gnt", 64'(d_gnt), 64'(1));
        step(); d_req = 1'b0; reset = 1'b1;
        step(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        samp();
        chk("t5_d_rvalid", 64'(d_rvalid), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        step(); mem_rvalid = 1'b0;
        samp();
        chk("t5_idle", 64'(busy), 64'(0));

        // Starvation: both requests held, memory latency 1
        fork mem_task(); join_none
        step();
        if_req = 1'b1; if_addr = 32'h0100_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_1000;
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        got = 0;
        for (int c = 0; c < TMO && got < 6; c++) begin
            samp();
            if (if_gnt) begin seq[got] = 1'b1; got++; end
            else if (d_gnt) begin seq[got] = 1'b0; got++; end
        end
        chk("t3_grant_count", 64'(got), 64'(6));
        for (int i = 0; i < got; i++)
            chk($sformatf("t3_order%0d_is_if", i), 64'(seq[i]), 64'(exp_seq[i]));
        step(); if_req = 1'b0; d_req = 1'b0;
        k = 0;
        do begin samp(); k++; end while (busy && k < TMO);
        chk("t3_drain", 64'(busy), 64'(0));

        // Random traffic against the scoreboard
        step();
        fixed_lat = 0; streak_m = 0; outst_m = 1'b0; owner_if_m = 1'b0;
        mon_en = 1'b1;
        fork
            fetch_task(NTXN);
            data_task(NTXN);
        join
        repeat (8) step();
        mon_en = 1'b0;
        chk("if_q_empty", 64'(exp_if_q.size()), 64'(0));
        chk("d_q_empty", 64'(exp_d_q.size()), 64'(0));
        mem_stop = 1'b1;
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
